// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one sync-read instruction RAM between CPU fetch and a word-write loader,
// with bounded loader priority, window range checks and a fixed 1-cycle fetch response.
module imem_port_arbiter #(
  parameter logic [29:0] BASE_WORD = 30'h00000c00,
  parameter logic [29:0] LAST_WORD = 30'h00000d00,
  parameter int          MAX_BURST = 4,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  output logic        fetch_err,
  input  logic        ld_valid,
  input  logic [29:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ready,
  output logic        ld_err,
  output logic [15:0] ld_count,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt;
  logic          resp_pending, resp_err;
  logic [31:0]   rdata_q;
  logic [29:0]   fw;
  logic          f_ok, l_ok, f_gnt, ld_gnt;
  always_comb begin
    fw           = fetch_addr[31:2];
    f_ok         = fetch_addr[1:0] == 2'b00 && fw >= BASE_WORD && fw <= LAST_WORD;
    l_ok         = ld_addr >= BASE_WORD && ld_addr <= LAST_WORD;
    ld_gnt       = rst_n && ld_valid && (!fetch_valid || burst_cnt < BW'(MAX_BURST));
    f_gnt        = rst_n && fetch_valid && !ld_gnt;
    fetch_ready  = f_gnt;
    ld_ready     = ld_gnt;
    mem_we       = ld_gnt && l_ok;
    mem_en       = (f_gnt && f_ok) || mem_we;
    mem_addr     = (f_gnt && f_ok) ? fw : mem_we ? ld_addr : '0;
    mem_wdata    = mem_we ? ld_wdata : '0;
    fetch_rvalid = resp_pending;
    fetch_err    = resp_err;
    // RAM data is only valid in the response cycle, so the held copy covers idle cycles
    fetch_rdata  = resp_pending ? (resp_err ? NOP_WORD : mem_rdata) : rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt    <= '0;
      resp_pending <= 1'b0;
      resp_err     <= 1'b0;
      rdata_q      <= '0;
      ld_err       <= 1'b0;
      ld_count     <= '0;
    end else begin
      resp_pending <= f_gnt;
      resp_err     <= f_gnt && !f_ok;
      if (resp_pending) rdata_q <= fetch_rdata;
      ld_err       <= ld_gnt && !l_ok;
      if (mem_we && ld_count != 16'hFFFF) ld_count <= ld_count + 1'b1;
      burst_cnt    <= (!fetch_valid || f_gnt) ? '0 : ld_gnt ? burst_cnt + 1'b1 : burst_cnt;
    end
  end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed vectors with hand-computed expectations against a behavioural RAM.
module tb_imem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready, fetch_rvalid, fetch_err;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        ld_valid, ld_ready, ld_err;
  logic [29:0] ld_addr;
  logic [31:0] ld_wdata;
  logic [15:0] ld_count;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:4095];
  int n_tot = 0;
  int n_bad = 0;

  imem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .ld_err(ld_err), .ld_count(ld_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    else if (mem_en) mem_rdata <= mem[mem_addr[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fa, input logic lv,
                       input logic [29:0] la, input logic [31:0] wd);
    @(posedge clk);
    #1;
    fetch_valid = fv; fetch_addr = fa; ld_valid = lv; ld_addr = la; ld_wdata = wd;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'hc00] = 32'h11; mem[12'hc01] = 32'h22; mem[12'hc02] = 32'h33; mem[12'hd00] = 32'h44;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    fetch_valid = 1'b1; fetch_addr = 32'h3000; ld_valid = 1'b1; ld_addr = 30'hc00; ld_wdata = 32'h5;
    #12;
    chk("rst_rvalid", fetch_rvalid, 0);
    chk("rst_rdata", fetch_rdata, 0);
    chk("rst_fready", fetch_ready, 0);
    chk("rst_lready", ld_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_count", ld_count, 0);
    chk("rst_ld_err", ld_err, 0);
    fetch_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // back-to-back in-range fetches
    drive(1, 32'h3000, 0, 0, 0);
    chk("t1_ready0", fetch_ready, 1);
    chk("t1_addr0", mem_addr, 30'hc00);
    chk("t1_en0", mem_en, 1);
    drive(1, 32'h3004, 0, 0, 0);
    chk("t1_rv0", fetch_rvalid, 1);
    chk("t1_rd0", fetch_rdata, 32'h11);
    drive(1, 32'h3008, 0, 0, 0);
    chk("t1_rd1", fetch_rdata, 32'h22);
    chk("t1_err1", fetch_err, 0);
    drive(0, 0, 0, 0, 0);
    chk("t1_rd2", fetch_rdata, 32'h33);
    chk("t1_idle_addr", mem_addr, 0);
    drive(0, 0, 0, 0, 0);
    chk("t1_rv_idle", fetch_rvalid, 0);
    chk("t1_rd_hold", fetch_rdata, 32'h33);
    // window edges and misalignment
    drive(1, 32'h2ffc, 0, 0, 0);
    chk("t2_en_low", mem_en, 0);
    chk("t2_ready_low", fetch_ready, 1);
    drive(1, 32'h3402, 0, 0, 0);
    chk("t2_en_mis", mem_en, 0);
    chk("t2_err_low", fetch_err, 1);
    chk("t2_rd_low", fetch_rdata, 0);
    drive(1, 32'h3400, 0, 0, 0);
    chk("t2_en_top", mem_en, 1);
    chk("t2_addr_top", mem_addr, 30'hd00);
    chk("t2_err_mis", fetch_err, 1);
    chk("t2_rv_mis", fetch_rvalid, 1);
    drive(0, 0, 0, 0, 0);
    chk("t2_err_top", fetch_err, 0);
    chk("t2_rd_top", fetch_rdata, 32'h44);
    drive(0, 0, 0, 0, 0);
    chk("t2_err_idle", fetch_err, 0);
    // loader write, then read-after-write, then out-of-range write
    drive(0, 0, 1, 30'hc05, 32'hdeadbeef);
    chk("t4_lready", ld_ready, 1);
    chk("t4_we", mem_we, 1);
    chk("t4_addr", mem_addr, 30'hc05);
    chk("t4_wdata", mem_wdata, 32'hdeadbeef);
    drive(1, 32'h3014, 0, 0, 0);
    chk("t4_rd_we", mem_we, 0);
    chk("t4_count1", ld_count, 1);
    drive(0, 0, 1, 30'hd01, 32'h12345678);
    chk("t4_raw", fetch_rdata, 32'hdeadbeef);
    chk("t4_oor_en", mem_en, 0);
    chk("t4_oor_ready", ld_ready, 1);
    drive(0, 0, 0, 0, 0);
    chk("t4_ld_err", ld_err, 1);
    chk("t4_count_hold", ld_count, 1);
    drive(0, 0, 0, 0, 0);
    chk("t4_ld_err_clr", ld_err, 0);
    // contention: L,L,L,L,F repeating
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'h3000, 1, 30'hc10, i);
      chk($sformatf("t3_f%0d", i), fetch_ready, (i == 4 || i == 9) ? 1 : 0);
      chk($sformatf("t3_l%0d", i), ld_ready, (i == 4 || i == 9) ? 0 : 1);
    end
    drive(0, 0, 0, 0, 0);
    chk("t3_count", ld_count, 11);
    // asynchronous reset one cycle after a fetch grant
    drive(1, 32'h3000, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("t5_rv_before", fetch_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rv_async", fetch_rvalid, 0);
    chk("t5_fready_rst", fetch_ready, 0);
    chk("t5_count_rst", ld_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h3000, 1, 30'hc20, i);
      chk($sformatf("t5_f%0d", i), fetch_ready, (i == 4) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0);
    chk("t5_count", ld_count, 4);
    // ld_count saturation
    for (int i = 0; i < 65530; i++) drive(0, 0, 1, 30'hc30, i);
    drive(0, 0, 0, 0, 0);
    chk("t6_fffe", ld_count, 16'hfffe);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 30'hc31, i);
    drive(0, 0, 0, 0, 0);
    chk("t6_sat", ld_count, 16'hffff);
    chk("t6_ld_err", ld_err, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
